// File: rtl/decoder_pkg.sv
// Shared types and legal parameter ranges for the decoder_n_strobe block.
package decoder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int SEL_W_MIN     = 1;
  localparam int SEL_W_MAX     = 6;
  localparam int PULSE_LEN_MIN = 1;
  localparam int PULSE_LEN_MAX = 255;

endpackage

// File: rtl/decoder_n_strobe_onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder; all zeros when en is low.
module onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [2**SEL_W-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_n_strobe.sv
// Strobes one decoded line for PULSE_LEN cycles per accepted start.
// Define DEC_ACT_LOW_OUT_EN for active-low y outputs.
module decoder_n_strobe
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int PULSE_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_n,
  input  logic [SEL_W-1:0]    sel,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [2**SEL_W-1:0] y
);

  localparam int N     = 2**SEL_W;
  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
`ifdef DEC_ACT_LOW_OUT_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif
  localparam logic [N-1:0] Y_IDLE = ACT_LOW ? {N{1'b1}} : {N{1'b0}};

  if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX) begin : g_sel_w_range
    $error("decoder_n_strobe: SEL_W out of range");
  end
  if (PULSE_LEN < PULSE_LEN_MIN || PULSE_LEN > PULSE_LEN_MAX) begin : g_pulse_len_range
    $error("decoder_n_strobe: PULSE_LEN out of range");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done_n;
  logic             load;
  logic             clear;
  logic [N-1:0]     onehot;
  logic [N-1:0]     y_n;

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel    (sel),
    .en     (load),
    .onehot (onehot)
  );

  // NOTE: every output is assigned a default first so no path leaves a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !en_n) begin
          load    = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (en_n) begin
          // Abort: drop the strobe silently.
          clear   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == '0) begin
          done_n = 1'b1;
          if (start) begin
            // Back-to-back: the completion cycle is the next strobe's first.
            load  = 1'b1;
            cnt_n = CNT_LOAD;
          end else begin
            clear   = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    y_n = y;
    if (load)       y_n = ACT_LOW ? ~onehot : onehot;
    else if (clear) y_n = Y_IDLE;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      y     <= Y_IDLE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
      y     <= y_n;
    end
  end

  assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_decoder_n_strobe.sv
// Directed bench: SEL_W=2/PULSE_LEN=4 instance (a) and SEL_W=3/PULSE_LEN=1 instance (b).
module tb_decoder_n_strobe;

`ifdef DEC_ACT_LOW_OUT_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en_n_a, start_a, busy_a, done_a;
  logic [1:0] sel_a;
  logic [3:0] y_a;
  logic       en_n_b, start_b, busy_b, done_b;
  logic [2:0] sel_b;
  logic [7:0] y_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_n_strobe #(.SEL_W(2), .PULSE_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .en_n(en_n_a), .sel(sel_a), .start(start_a),
    .busy(busy_a), .done(done_a), .y(y_a)
  );

  decoder_n_strobe #(.SEL_W(3), .PULSE_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .en_n(en_n_b), .sel(sel_b), .start(start_b),
    .busy(busy_b), .done(done_b), .y(y_b)
  );

  // Expected y for a given active index; negative index means all inactive.
  function automatic logic [3:0] ya(input int idx);
    logic [3:0] v;
    v = '0;
    if (idx >= 0) v[idx[1:0]] = 1'b1;
    return ACT_LOW ? ~v : v;
  endfunction

  function automatic logic [7:0] yb(input int idx);
    logic [7:0] v;
    v = '0;
    if (idx >= 0) v[idx[2:0]] = 1'b1;
    return ACT_LOW ? ~v : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    #1;
    exp = {1'b0, 1'b0, ya(-1)};
    tests++;
    if ({busy_a, done_a, y_a} !== exp) begin
      fails++;
      $display("FAIL reset_a: got %b want %b", {busy_a, done_a, y_a}, exp);
    end
    tests++;
    if ({busy_b, done_b, y_b} !== {1'b0, 1'b0, yb(-1)}) begin
      fails++;
      $display("FAIL reset_b: got %b want %b", {busy_b, done_b, y_b}, {1'b0, 1'b0, yb(-1)});
    end
    // A start held during reset must not be taken.
    start_a = 1'b1;
    sel_a   = 2'd3;
    step();
    tests++;
    if ({busy_a, done_a, y_a} !== exp) begin
      fails++;
      $display("FAIL reset_hold_start: got %b want %b", {busy_a, done_a, y_a}, exp);
    end
    start_a = 1'b0;
    rst     = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [5:0] exp;
    start_a = 1'b1;
    sel_a   = 2'd2;
    step();
    start_a = 1'b0;
    sel_a   = 2'd0;
    for (int c = 0; c <= 5; c++) begin
      if (c < 4)       exp = {1'b1, 1'b0, ya(2)};
      else if (c == 4) exp = {1'b0, 1'b1, ya(-1)};
      else             exp = {1'b0, 1'b0, ya(-1)};
      tests++;
      if ({busy_a, done_a, y_a} !== exp) begin
        fails++;
        $display("FAIL single c%0d: got %b want %b", c, {busy_a, done_a, y_a}, exp);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    start_a = 1'b1;
    sel_a   = 2'd1;
    step();
    for (int c = 0; c <= 13; c++) begin
      if (c == 12)      exp = {1'b0, 1'b1, ya(-1)};
      else if (c == 13) exp = {1'b0, 1'b0, ya(-1)};
      else              exp = {1'b1, (c == 4 || c == 8), ya(1)};
      tests++;
      if ({busy_a, done_a, y_a} !== exp) begin
        fails++;
        $display("FAIL back_to_back c%0d: got %b want %b", c, {busy_a, done_a, y_a}, exp);
      end
      if (c == 8) start_a = 1'b0;
      step();
    end
  endtask

  task automatic test_abort();
    logic [5:0] exp;
    start_a = 1'b1;
    sel_a   = 2'd3;
    step();
    start_a = 1'b0;
    step();
    exp = {1'b1, 1'b0, ya(3)};
    tests++;
    if ({busy_a, done_a, y_a} !== exp) begin
      fails++;
      $display("FAIL abort_pre: got %b want %b", {busy_a, done_a, y_a}, exp);
    end
    en_n_a = 1'b1;
    exp = {1'b0, 1'b0, ya(-1)};
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if ({busy_a, done_a, y_a} !== exp) begin
        fails++;
        $display("FAIL abort c%0d: got %b want %b", c, {busy_a, done_a, y_a}, exp);
      end
    end
    // Disabled block ignores start entirely.
    start_a = 1'b1;
    sel_a   = 2'd0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({busy_a, done_a, y_a} !== exp) begin
        fails++;
        $display("FAIL disabled_start c%0d: got %b want %b", c, {busy_a, done_a, y_a}, exp);
      end
    end
    start_a = 1'b0;
    en_n_a  = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    start_a = 1'b1;
    sel_a   = 2'd2;
    step();
    start_a = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    exp = {1'b0, 1'b0, ya(-1)};
    tests++;
    if ({busy_a, done_a, y_a} !== exp) begin
      fails++;
      $display("FAIL reset_mid_async: got %b want %b", {busy_a, done_a, y_a}, exp);
    end
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      tests++;
      if ({busy_a, done_a, y_a} !== exp) begin
        fails++;
        $display("FAIL reset_mid_after c%0d: got %b want %b", c, {busy_a, done_a, y_a}, exp);
      end
    end
  endtask

  task automatic test_pulse1();
    logic [9:0] exp [0:6];
    exp[0] = {1'b1, 1'b0, yb(7)};
    exp[1] = {1'b0, 1'b1, yb(-1)};
    exp[2] = {1'b0, 1'b0, yb(-1)};
    exp[3] = {1'b1, 1'b0, yb(5)};
    exp[4] = {1'b1, 1'b1, yb(5)};
    exp[5] = {1'b0, 1'b1, yb(-1)};
    exp[6] = {1'b0, 1'b0, yb(-1)};
    start_b = 1'b1;
    sel_b   = 3'd7;
    for (int c = 0; c <= 6; c++) begin
      step();
      case (c)
        0: start_b = 1'b0;
        2: begin start_b = 1'b1; sel_b = 3'd5; end
        4: start_b = 1'b0;
        default: ;
      endcase
      tests++;
      if ({busy_b, done_b, y_b} !== exp[c]) begin
        fails++;
        $display("FAIL pulse1 c%0d: got %b want %b", c, {busy_b, done_b, y_b}, exp[c]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    en_n_a  = 1'b0;
    start_a = 1'b0;
    sel_a   = '0;
    en_n_b  = 1'b0;
    start_b = 1'b0;
    sel_b   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_pulse1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_n_strobe.md
DECODER_N_STROBE -- requirements
Module: decoder_n_strobe

Interface
REQ-001 SHALL have parameter SEL_W, default 2: select width; decoded output width is 2**SEL_W; legal range 1..6.
REQ-002 SHALL have parameter PULSE_LEN, default 4: strobe length in clock cycles; legal range 1..255.
REQ-003 SHALL provide clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL provide rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL provide en_n, input, 1: block enable, active-low.
REQ-006 SHALL provide sel, input, SEL_W: line to decode, sampled only on an accepted start.
REQ-007 SHALL provide start, input, 1: strobe request, single-cycle or level; sampled each rising edge.
REQ-008 SHALL provide busy, output, 1: high while a strobe is in progress.
REQ-009 SHALL provide done, output, 1: one-cycle pulse on normal strobe completion.
REQ-010 SHALL provide y, output, 2**SEL_W: registered decoded strobe outputs, polarity per REQ-027.

Function
REQ-011 SHALL implement an FSM with states IDLE and ACTIVE.
REQ-012 In IDLE, a start accepted when start=1 and en_n=0 at a rising edge; sel captured on that same edge.
REQ-013 Accepted start at edge E0: state ACTIVE and busy=1 from E0; y[sel_captured] asserted from E0 until edge E0+PULSE_LEN, i.e. exactly PULSE_LEN cycles; all other y bits inactive.
REQ-014 At edge E0+PULSE_LEN: y all inactive, busy=0, state IDLE, done=1 for exactly that one cycle.
REQ-015 A start accepted on the edge where done rises SHALL begin a new strobe (back-to-back strobes, one inactive cycle between them is NOT inserted: done cycle is the new strobe's first cycle, done=1 and busy=1 simultaneously).
REQ-016 start while ACTIVE (other than REQ-015 edge) SHALL be ignored; no queueing; sel changes while ACTIVE SHALL not affect y.
REQ-017 start with en_n=1 SHALL be ignored.
REQ-018 en_n=1 sampled in ACTIVE SHALL abort: at that edge y all inactive, busy=0, state IDLE, done stays 0.
REQ-019 Down-counter width SHALL be clog2(PULSE_LEN+1); loaded with PULSE_LEN-1 on accept, decrements each ACTIVE cycle, no wrap below 0.
REQ-020 PULSE_LEN=1: y active exactly one cycle, done on the following edge.
REQ-021 At most one y bit SHALL be active at any cycle (one-hot or all-inactive); no combinational path from inputs to y, busy or done.

Reset
REQ-022 rst=1 SHALL immediately, without a clock edge, force state IDLE, counter 0, busy=0, done=0, y all inactive.
REQ-023 rst asserted mid-strobe SHALL discard the strobe; no done is generated.
REQ-024 After rst deasserts, the first start is accepted no earlier than the first rising edge with rst=0.

Configuration
REQ-025 Macro DEC_ACT_LOW_OUT_EN SHALL select y polarity.
REQ-026 With DEC_ACT_LOW_OUT_EN defined, active y bit = 0 and inactive = 1 (reset value all ones).
REQ-027 Without it, active y bit = 1 and inactive = 0 (reset value all zeros); busy, done, en_n polarity unaffected in both cases.

Structure
REQ-028 Package decoder_pkg SHALL hold the state typedef (IDLE, ACTIVE) and the SEL_W/PULSE_LEN legal-range constants.
REQ-029 Sub-module onehot_dec (combinational SEL_W-to-2**SEL_W decoder with enable) SHALL produce the one-hot vector, registered in decoder_n_strobe.
REQ-030 Out-of-range parameters SHALL fail elaboration.

Verification
REQ-031 SEL_W=2, PULSE_LEN=4, en_n=0, start pulse with sel=2 -> y[2] active 4 cycles, busy 4 cycles, done one cycle after, other bits inactive throughout.
REQ-032 sel=1 strobe, start held high continuously -> back-to-back strobes with done and busy both 1 at each boundary edge, y[1] continuously active.
REQ-033 sel=3 strobe, en_n=1 in second active cycle -> y inactive and busy=0 next edge, no done; start with en_n=1 -> no response.
REQ-034 rst asserted between edges during strobe -> y, busy, done inactive before next edge; no done after release.
REQ-035 PULSE_LEN=1, SEL_W=3, sel=7 -> y[7] active one cycle, done next; repeat both with and without DEC_ACT_LOW_OUT_EN and check polarity and one-hot assertion.
